step_pulse_gen: RTL and testbench

Downstream consumer of the shift-add multiplier's product. Takes a computed step period in clock cycles and a step count, then emits a train of fixed-width STEP pulses with a DIR setup window before the first pulse. Drives the driver IC's STEP/DIR pins and reports busy/done back to the motion sequencer.

---
 rtl/step_pulse_gen_pkg.sv | 16 +
 rtl/step_pulse_gen_if.sv | 29 ++
 rtl/step_pulse_gen_phase_timer.sv | 27 ++
 rtl/step_pulse_gen.sv | 188 ++++++++++++++++++
 tb/tb_step_pulse_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared stepper definitions: FSM state encoding and the default STEP/DIR
// timing that the driver IC requires.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  // Driver-IC minimums: STEP high time and DIR-to-STEP setup, in clocks.
  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_SETUP_CYCLES = 2;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Sequencer <-> step pulse generator signal bundle; the slave side is the
// generator, the master side is the motion sequencer.
interface step_pulse_gen_if #(
  parameter int N_BITS   = 32,
  parameter int CNT_BITS = 16
);

  logic [N_BITS-1:0]   period;
  logic [CNT_BITS-1:0] steps;
  logic                dir_in;
  logic                start;
  logic                abort;
  logic                step_out;
  logic                dir_out;
  logic                busy;
  logic                done;
  logic [CNT_BITS-1:0] steps_left;

  modport master (
    output period, steps, dir_in, start, abort,
    input  step_out, dir_out, busy, done, steps_left
  );

  modport slave (
    input  period, steps, dir_in, start, abort,
    output step_out, dir_out, busy, done, steps_left
  );

endinterface

// File: rtl/step_pulse_gen_phase_timer.sv
// Loadable down-counter timing one phase; expire is high during the last
// clock of the loaded length, and the count parks at zero instead of wrapping.
module step_pulse_gen_phase_timer #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N_BITS-1:0] value,
  output logic              expire
);

  logic [N_BITS-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - N_BITS'(1);
    end
  end

  assign expire = (count == N_BITS'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse train generator: DIR setup window, then steps pulses spaced
// by the latched (clamped) period, with abort and one-cycle done reporting.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int N_BITS       = 32,
  parameter int CNT_BITS     = 16,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
  input logic             clk,
  input logic             rst,
  step_pulse_gen_if.slave bus
);

  localparam logic [N_BITS-1:0] MIN_P     = N_BITS'(2 * PULSE_CYCLES);
  localparam logic [N_BITS-1:0] PULSE_LEN = N_BITS'(PULSE_CYCLES);
  localparam logic [N_BITS-1:0] SETUP_LEN = N_BITS'(SETUP_CYCLES);

  // The period floor guarantees a LOW phase at least as long as the pulse.
  function automatic logic [N_BITS-1:0] clamp_period(input logic [N_BITS-1:0] p);
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  state_t              state, state_nxt;
  logic                start_q;
  logic                rise;
  logic                abort_pend, abort_pend_nxt;
  logic                step_q, step_nxt;
  logic                dir_q, dir_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;
  logic [CNT_BITS-1:0] left_q, left_nxt;
  logic [N_BITS-1:0]   low_len;
  logic                latch_p;
  logic                tmr_load;
  logic [N_BITS-1:0]   tmr_value;
  logic                tmr_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= bus.start;
    end
  end

  assign rise = bus.start & ~start_q;

  step_pulse_gen_phase_timer #(
    .N_BITS(N_BITS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // LOW length is fixed for the whole move, so a mid-move period change is ignored.
  always_ff @(posedge clk) begin
    if (latch_p) begin
      low_len <= clamp_period(bus.period) - PULSE_LEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    abort_pend_nxt = abort_pend;
    step_nxt       = step_q;
    dir_nxt        = dir_q;
    busy_nxt       = busy_q;
    done_nxt       = 1'b0;
    left_nxt       = left_q;
    latch_p        = 1'b0;
    tmr_load       = 1'b0;
    tmr_value      = '0;

    case (state)
      IDLE: begin
        abort_pend_nxt = 1'b0;
        if (rise && !bus.abort) begin
          if (bus.steps == '0) begin
            done_nxt = 1'b1;
          end else begin
            dir_nxt   = bus.dir_in;
            left_nxt  = bus.steps;
            busy_nxt  = 1'b1;
            latch_p   = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = SETUP_LEN;
            state_nxt = SETUP;
          end
        end
      end

      SETUP: begin
        if (bus.abort) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          step_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = PULSE_LEN;
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        // An abort here is remembered so the pulse keeps its full width.
        if (bus.abort) begin
          abort_pend_nxt = 1'b1;
        end
        if (tmr_expire) begin
          step_nxt = 1'b0;
          left_nxt = left_q - CNT_BITS'(1);
          if (bus.abort || abort_pend) begin
            abort_pend_nxt = 1'b0;
            busy_nxt       = 1'b0;
            done_nxt       = 1'b1;
            state_nxt      = IDLE;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = low_len;
            state_nxt = LOW;
          end
        end
      end

      LOW: begin
        if (bus.abort) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          if (left_q != '0) begin
            step_nxt  = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = PULSE_LEN;
            state_nxt = HIGH;
          end else begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_pend <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      left_q     <= '0;
    end else begin
      abort_pend <= abort_pend_nxt;
      step_q     <= step_nxt;
      dir_q      <= dir_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      left_q     <= left_nxt;
    end
  end

  assign bus.step_out   = step_q;
  assign bus.dir_out    = dir_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_left = left_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: nominal train, zero steps, period clamp,
// abort mid-pulse, start edge handling and asynchronous reset mid-move.
module tb_step_pulse_gen;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  step_pulse_gen_if #(.N_BITS(32), .CNT_BITS(16)) bus ();

  step_pulse_gen #(
    .N_BITS(32),
    .CNT_BITS(16),
    .PULSE_CYCLES(4),
    .SETUP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Tick through edges E<k0>..E<k1> of a move launched at E0 with effective
  // period p and n steps (setup 2, pulse 4), checking outputs after each edge.
  task automatic expect_train(input string name, input int p, input int n,
                              input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      int   end_k;
      int   fell;
      logic e_step;
      end_k  = 2 + n * p;
      e_step = (k >= 2) && (((k - 2) / p) < n) && (((k - 2) % p) < 4);
      fell   = (k < 6) ? 0 : ((k - 6) / p + 1);
      if (fell > n) fell = n;
      tick();
      check($sformatf("%s step_out E%0d", name, k), 32'(bus.step_out), 32'(e_step));
      check($sformatf("%s steps_left E%0d", name, k), 32'(bus.steps_left), 32'(n - fell));
      check($sformatf("%s busy E%0d", name, k), 32'(bus.busy), 32'(k < end_k));
      check($sformatf("%s done E%0d", name, k), 32'(bus.done), 32'(k == end_k));
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    rst         = 1'b1;
    bus.period  = '0;
    bus.steps   = '0;
    bus.dir_in  = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    tick();
    tick();
    check("reset step_out", 32'(bus.step_out), 0);
    check("reset dir_out", 32'(bus.dir_out), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset steps_left", 32'(bus.steps_left), 0);
    rst = 1'b0;
    tick();

    // Nominal move: period 10, 3 steps, dir 1.
    bus.period = 32'd10;
    bus.steps  = 16'd3;
    bus.dir_in = 1'b1;
    bus.start  = 1'b1;
    expect_train("nominal", 10, 3, 0, 0);
    check("nominal dir_out", 32'(bus.dir_out), 1);
    bus.start = 1'b0;
    expect_train("nominal", 10, 3, 1, 34);

    // Zero steps: done pulse only, dir_out keeps its old value.
    bus.steps  = 16'd0;
    bus.dir_in = 1'b0;
    bus.start  = 1'b1;
    tick();
    check("zero done", 32'(bus.done), 1);
    check("zero busy", 32'(bus.busy), 0);
    check("zero step_out", 32'(bus.step_out), 0);
    check("zero dir_out", 32'(bus.dir_out), 1);
    bus.start = 1'b0;
    tick();
    check("zero done drop", 32'(bus.done), 0);
    check("zero busy after", 32'(bus.busy), 0);

    // Period clamp: 3 and 0 both act as 8.
    bus.period = 32'd3;
    bus.steps  = 16'd2;
    bus.start  = 1'b1;
    expect_train("clamp3", 8, 2, 0, 0);
    check("clamp3 dir_out", 32'(bus.dir_out), 0);
    bus.start = 1'b0;
    expect_train("clamp3", 8, 2, 1, 20);
    bus.period = 32'd0;
    bus.start  = 1'b1;
    expect_train("clamp0", 8, 2, 0, 0);
    bus.start = 1'b0;
    expect_train("clamp0", 8, 2, 1, 20);

    // Abort one clock into pulse 2's HIGH (pulse 2 rises at E22).
    bus.period = 32'd20;
    bus.steps  = 16'd5;
    bus.dir_in = 1'b1;
    bus.start  = 1'b1;
    expect_train("abort", 20, 5, 0, 0);
    bus.start = 1'b0;
    expect_train("abort", 20, 5, 1, 23);
    bus.abort = 1'b1;
    tick();
    check("abort E24 step_out", 32'(bus.step_out), 1);
    check("abort E24 busy", 32'(bus.busy), 1);
    bus.abort = 1'b0;
    tick();
    check("abort E25 step_out", 32'(bus.step_out), 1);
    check("abort E25 done", 32'(bus.done), 0);
    tick();
    check("abort E26 step_out", 32'(bus.step_out), 0);
    check("abort E26 steps_left", 32'(bus.steps_left), 3);
    check("abort E26 busy", 32'(bus.busy), 0);
    check("abort E26 done", 32'(bus.done), 1);
    for (int k = 27; k < 57; k++) begin
      tick();
      check($sformatf("abort quiet step_out E%0d", k), 32'(bus.step_out), 0);
      check($sformatf("abort quiet done E%0d", k), 32'(bus.done), 0);
    end
    check("abort steps_left held", 32'(bus.steps_left), 3);

    // Start held high through the move plus a second rise: one move only.
    bus.period = 32'd8;
    bus.steps  = 16'd2;
    bus.start  = 1'b1;
    expect_train("held", 8, 2, 0, 4);
    bus.start = 1'b0;
    expect_train("held", 8, 2, 5, 6);
    bus.start = 1'b1;
    expect_train("held", 8, 2, 7, 24);
    // Fresh rise after done launches a second move.
    bus.start = 1'b0;
    tick();
    bus.period = 32'd9;
    bus.steps  = 16'd1;
    bus.start  = 1'b1;
    expect_train("relaunch", 9, 1, 0, 14);

    // Abort and rise in the same IDLE cycle: nothing happens.
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check("abort+rise busy", 32'(bus.busy), 0);
    check("abort+rise done", 32'(bus.done), 0);
    bus.abort = 1'b0;
    tick();
    check("abort+rise busy later", 32'(bus.busy), 0);
    check("abort+rise done later", 32'(bus.done), 0);

    // Async reset while STEP is high.
    bus.start = 1'b0;
    tick();
    bus.period = 32'd10;
    bus.steps  = 16'd3;
    bus.start  = 1'b1;
    expect_train("prereset", 10, 3, 0, 3);
    bus.start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst step_out", 32'(bus.step_out), 0);
    check("async rst busy", 32'(bus.busy), 0);
    check("async rst steps_left", 32'(bus.steps_left), 0);
    check("async rst dir_out", 32'(bus.dir_out), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post rst busy", 32'(bus.busy), 0);
    bus.steps = 16'd2;
    bus.start = 1'b1;
    expect_train("postreset", 10, 2, 0, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
